parking_space_controller: RTL and testbench

- Sequencer for an 8-space parking lot. Keeps the free-space bitmap and gives each entering car the lowest-numbered free space.
- Drives the entry gate for a fixed dwell time and returns spaces to the pool when cars exit.
- Sits between the entry/exit sensors and the lot display. Its parking_capacity and park_number outputs feed the existing space-number encoding and display logic.

---
 rtl/parking_space_controller.sv | 125 ++++++++++++
 tb/tb_parking_space_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/parking_space_controller.sv
// Parking-lot sequencer: keeps the free-space bitmap, hands each entering car
// the lowest free space, times the entry gate and returns spaces on exit.
module parking_space_controller #(
  parameter int N_SPACES    = 8,
  parameter int GATE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                entry_req,
  input  logic                exit_req,
  input  logic [2:0]          exit_space,
  output logic [N_SPACES-1:0] parking_capacity,
  output logic [2:0]          park_number,
  output logic                park_valid,
  output logic                entry_denied,
  output logic                gate_open,
  output logic                full,
  output logic [3:0]          free_count,
  output logic                exit_error
);

  typedef enum logic {IDLE, GATE} state_t;

  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          gate_cnt_q, gate_cnt_d;
  logic [N_SPACES-1:0] map_q, map_d;
  logic [2:0]          park_number_q, park_number_d;
  logic                park_valid_q, park_valid_d;
  logic                entry_denied_q, entry_denied_d;
  logic                gate_open_q, gate_open_d;
  logic [3:0]          free_count_q, free_count_d;
  logic                exit_error_q, exit_error_d;

  logic [2:0] low_idx;
  logic       alloc;
  logic       exit_ok;

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    low_idx = '0;
    for (int i = N_SPACES - 1; i >= 0; i--) begin
      if (map_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    gate_cnt_d     = gate_cnt_q;
    map_d          = map_q;
    park_number_d  = park_number_q;
    park_valid_d   = 1'b0;
    entry_denied_d = 1'b0;
    gate_open_d    = gate_open_q;
    exit_error_d   = 1'b0;

    // Selection and the full check both look at the pre-exit map.
    alloc   = (state_q == IDLE) && entry_req && (map_q != '0);
    exit_ok = exit_req && !map_q[exit_space];

    case (state_q)
      IDLE: begin
        if (alloc) begin
          park_number_d = low_idx;
          park_valid_d  = 1'b1;
          gate_open_d   = 1'b1;
          gate_cnt_d    = GATE_LOAD;
          state_d       = GATE;
        end else if (entry_req) begin
          entry_denied_d = 1'b1;
        end
      end
      GATE: begin
        if (gate_cnt_q == 4'd0) begin
          gate_open_d = 1'b0;
          state_d     = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (alloc) map_d[low_idx] = 1'b0;
    if (exit_ok) map_d[exit_space] = 1'b1;
    if (exit_req && !exit_ok) exit_error_d = 1'b1;

    free_count_d = free_count_q + {3'b000, exit_ok} - {3'b000, alloc};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      gate_cnt_q     <= '0;
      map_q          <= '1;
      park_number_q  <= '0;
      park_valid_q   <= 1'b0;
      entry_denied_q <= 1'b0;
      gate_open_q    <= 1'b0;
      free_count_q   <= 4'(N_SPACES);
      exit_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      gate_cnt_q     <= gate_cnt_d;
      map_q          <= map_d;
      park_number_q  <= park_number_d;
      park_valid_q   <= park_valid_d;
      entry_denied_q <= entry_denied_d;
      gate_open_q    <= gate_open_d;
      free_count_q   <= free_count_d;
      exit_error_q   <= exit_error_d;
    end
  end

  assign parking_capacity = map_q;
  assign park_number      = park_number_q;
  assign park_valid       = park_valid_q;
  assign entry_denied     = entry_denied_q;
  assign gate_open        = gate_open_q;
  assign full             = (map_q == '0);
  assign free_count       = free_count_q;
  assign exit_error       = exit_error_q;

endmodule

// File: tb/tb_parking_space_controller.sv
// Directed, table-driven bench for parking_space_controller; each row gives the
// inputs applied before a rising edge and the outputs expected just after it.
module tb_parking_space_controller;

  logic       clk;
  logic       reset_n;
  logic       entry_req;
  logic       exit_req;
  logic [2:0] exit_space;
  logic [7:0] parking_capacity;
  logic [2:0] park_number;
  logic       park_valid;
  logic       entry_denied;
  logic       gate_open;
  logic       full;
  logic [3:0] free_count;
  logic       exit_error;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    int         tag;
    logic       rst_n;
    logic       er;
    logic       xr;
    logic [2:0] xs;
    logic       pv;
    logic [2:0] pn;
    logic [7:0] map;
    logic [3:0] fc;
    logic       den;
    logic       go;
    logic       xe;
  } vec_t;

  vec_t vecs[$];

  parking_space_controller #(.N_SPACES(8), .GATE_CYCLES(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .entry_req        (entry_req),
    .exit_req         (exit_req),
    .exit_space       (exit_space),
    .parking_capacity (parking_capacity),
    .park_number      (park_number),
    .park_valid       (park_valid),
    .entry_denied     (entry_denied),
    .gate_open        (gate_open),
    .full             (full),
    .free_count       (free_count),
    .exit_error       (exit_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int tag, input logic rst_n, input logic er, input logic xr,
                     input logic [2:0] xs, input logic pv, input logic [2:0] pn,
                     input logic [7:0] map, input logic [3:0] fc, input logic den,
                     input logic go, input logic xe);
    vec_t v;
    v.tag = tag; v.rst_n = rst_n; v.er = er; v.xr = xr; v.xs = xs;
    v.pv = pv; v.pn = pn; v.map = map; v.fc = fc; v.den = den; v.go = go; v.xe = xe;
    vecs.push_back(v);
  endtask

  task automatic cmp(input int tag, input string field, input logic [7:0] act,
                     input logic [7:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL t%0d/%s: got %0h, want %0h at %0t", tag, field, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic er, input logic xr,
                                input logic [2:0] xs);
    @(negedge clk);
    reset_n    = rst_n;
    entry_req  = er;
    exit_req   = xr;
    exit_space = xs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input int tag, input logic pv, input logic [2:0] pn,
                              input logic [7:0] map, input logic [3:0] fc,
                              input logic den, input logic go, input logic xe);
    cmp(tag, "park_valid",       8'(park_valid),   8'(pv));
    cmp(tag, "park_number",      8'(park_number),  8'(pn));
    cmp(tag, "parking_capacity", parking_capacity, map);
    cmp(tag, "free_count",       8'(free_count),   8'(fc));
    cmp(tag, "entry_denied",     8'(entry_denied), 8'(den));
    cmp(tag, "gate_open",        8'(gate_open),    8'(go));
    cmp(tag, "exit_error",       8'(exit_error),   8'(xe));
    cmp(tag, "full",             8'(full),         8'(map == 8'h00));
  endtask

  task automatic add_gate_tail(input int tag, input logic [2:0] pn, input logic [7:0] map,
                               input logic [3:0] fc);
    for (int j = 0; j < 3; j++) add(tag, 1, 0, 0, 0, 0, pn, map, fc, 0, 1, 0);
    add(tag, 1, 0, 0, 0, 0, pn, map, fc, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] one;

    reset_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_space = 3'd0;

    // First car after reset; gate high for exactly four cycles.
    add(1, 0, 0, 0, 0, 0, 0, 8'hFF, 8, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 8'hFE, 7, 0, 1, 0);
    add_gate_tail(1, 0, 8'hFE, 7);
    add(1, 1, 0, 0, 0, 0, 0, 8'hFE, 7, 0, 0, 0);

    // Fill the lot in order, then get denied twice while the request is held.
    add(2, 0, 0, 0, 0, 0, 0, 8'hFF, 8, 0, 0, 0);
    m = 8'hFF;
    one = 8'h01;
    for (int k = 0; k < 8; k++) begin
      m = m & ~(one << k);
      add(2, 1, 1, 0, 0, 1, 3'(k), m, 4'(7 - k), 0, 1, 0);
      add_gate_tail(2, 3'(k), m, 4'(7 - k));
    end
    add(2, 1, 1, 0, 0, 0, 7, 8'h00, 0, 1, 0, 0);
    add(2, 1, 1, 0, 0, 0, 7, 8'h00, 0, 1, 0, 0);
    add(2, 1, 0, 0, 0, 0, 7, 8'h00, 0, 0, 0, 0);

    // Exit space 5 from a full lot, then the next car lands in it.
    add(3, 1, 0, 1, 5, 0, 7, 8'h20, 1, 0, 0, 0);
    add(3, 1, 1, 0, 0, 1, 5, 8'h00, 0, 0, 1, 0);
    add_gate_tail(3, 5, 8'h00, 0);

    // Entry and exit together in a full lot: denied, then held request gets 2.
    add(4, 1, 1, 1, 2, 0, 5, 8'h04, 1, 1, 0, 0);
    add(4, 1, 1, 0, 0, 1, 2, 8'h00, 0, 0, 1, 0);
    add_gate_tail(4, 2, 8'h00, 0);

    // Exit of an already-free space.
    add(5, 0, 0, 0, 0, 0, 0, 8'hFF, 8, 0, 0, 0);
    add(5, 1, 0, 1, 3, 0, 0, 8'hFF, 8, 0, 0, 1);
    add(5, 1, 0, 0, 0, 0, 0, 8'hFF, 8, 0, 0, 0);

    // Allocation alongside a bad exit, a good exit during GATE, held request reused.
    add(7, 1, 1, 1, 0, 1, 0, 8'hFE, 7, 0, 1, 1);
    add(7, 1, 0, 1, 0, 0, 0, 8'hFF, 8, 0, 1, 0);
    add(7, 1, 1, 0, 0, 0, 0, 8'hFF, 8, 0, 1, 0);
    add(7, 1, 1, 0, 0, 0, 0, 8'hFF, 8, 0, 1, 0);
    add(7, 1, 1, 1, 6, 0, 0, 8'hFF, 8, 0, 0, 1);
    add(7, 1, 1, 0, 0, 1, 0, 8'hFE, 7, 0, 1, 0);
    add_gate_tail(7, 0, 8'hFE, 7);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst_n, vecs[i].er, vecs[i].xr, vecs[i].xs);
      check_output(vecs[i].tag, vecs[i].pv, vecs[i].pn, vecs[i].map, vecs[i].fc,
                   vecs[i].den, vecs[i].go, vecs[i].xe);
    end

    // Reset during GATE with three spaces taken; requests held through reset.
    apply_stimulus(0, 0, 0, 0);
    check_output(6, 0, 0, 8'hFF, 8, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1, 1, 0, 0);
      for (int j = 0; j < 4; j++) apply_stimulus(1, 0, 0, 0);
    end
    apply_stimulus(1, 1, 0, 0);
    check_output(6, 1, 2, 8'hF8, 5, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0);
    check_output(6, 0, 2, 8'hF8, 5, 0, 1, 0);
    apply_stimulus(0, 1, 1, 3);
    check_output(6, 0, 0, 8'hFF, 8, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    check_output(6, 0, 0, 8'hFF, 8, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output(6, 1, 0, 8'hFE, 7, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
